// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_pkg
// Brief   : 640x480@60 timing constants and shared sync-bundle types.
// Revision: 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_COUNT_W   = 10;

  typedef logic [VGA_COUNT_W-1:0] vga_count_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } vga_sync_t;

  // Syncs are active-low, so the idle bundle keeps them high with video blanked.
  localparam vga_sync_t VGA_SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

endpackage
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// ============================================================================
// Module  : sync_delay_line
// Brief   : WIDTH-bit, DEPTH-stage shift register with a reset pattern.
// Revision: 1.0 - initial release
// ============================================================================
module sync_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RESET_VAL;
      end
    end else begin
      r_stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign dout = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_sync_gen
// Brief   : VGA pixel tick, h/v counters, syncs and delayed sync copies.
// Revision: 1.0 - initial release
// ============================================================================
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY  = VGA_H_DISPLAY,
  parameter int H_FRONT    = VGA_H_FRONT,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BACK     = VGA_H_BACK,
  parameter int V_DISPLAY  = VGA_V_DISPLAY,
  parameter int V_FRONT    = VGA_V_FRONT,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BACK     = VGA_V_BACK,
  parameter int SYNC_DELAY = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       video_on_d,
  output logic       frame_start
);

  localparam int         c_h_total  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int         c_v_total  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam vga_count_t c_h_last   = vga_count_t'(c_h_total - 1);
  localparam vga_count_t c_v_last   = vga_count_t'(c_v_total - 1);
  localparam vga_count_t c_h_disp   = vga_count_t'(H_DISPLAY);
  localparam vga_count_t c_v_disp   = vga_count_t'(V_DISPLAY);
  localparam vga_count_t c_hs_first = vga_count_t'(H_DISPLAY + H_FRONT);
  localparam vga_count_t c_hs_last  = vga_count_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam vga_count_t c_vs_first = vga_count_t'(V_DISPLAY + V_FRONT);
  localparam vga_count_t c_vs_last  = vga_count_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [1:0] r_presc;
  vga_count_t r_h_count;
  vga_count_t r_v_count;
  logic       r_video_on;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_frame_start;

  logic       w_tick;
  logic       w_h_last;
  logic       w_v_last;
  vga_count_t w_h_next;
  vga_count_t w_v_next;
  vga_sync_t  w_sync_now;
  vga_sync_t  w_sync_dly;

  assign w_tick   = (r_presc == 2'd3);
  assign w_h_last = (r_h_count == c_h_last);
  assign w_v_last = (r_v_count == c_v_last);

  always_comb begin
    w_h_next = r_h_count;
    w_v_next = r_v_count;
    if (w_tick) begin
      w_h_next = w_h_last ? '0 : r_h_count + vga_count_t'(1);
      if (w_h_last) begin
        w_v_next = w_v_last ? '0 : r_v_count + vga_count_t'(1);
      end
    end
  end

  // Syncs and blanking come from the next-state counts so they move on the
  // same edge as pix_x/pix_y instead of one pixel late.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_presc       <= 2'd0;
      r_h_count     <= '0;
      r_v_count     <= '0;
      r_video_on    <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_presc       <= r_presc + 2'd1;
      r_h_count     <= w_h_next;
      r_v_count     <= w_v_next;
      r_video_on    <= (w_h_next < c_h_disp) && (w_v_next < c_v_disp);
      r_hsync       <= !((w_h_next >= c_hs_first) && (w_h_next <= c_hs_last));
      r_vsync       <= !((w_v_next >= c_vs_first) && (w_v_next <= c_vs_last));
      r_frame_start <= w_tick && w_h_last && w_v_last;
    end
  end

  assign w_sync_now = '{hsync: r_hsync, vsync: r_vsync, video_on: r_video_on};

  sync_delay_line #(
    .WIDTH     ($bits(vga_sync_t)),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (VGA_SYNC_IDLE)
  ) u_sync_delay (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .din     (w_sync_now),
    .dout    (w_sync_dly)
  );

  assign p_tick      = w_tick;
  assign pix_x       = r_h_count;
  assign pix_y       = r_v_count;
  assign video_on    = r_video_on;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;
  assign hsync_d     = w_sync_dly.hsync;
  assign vsync_d     = w_sync_dly.vsync;
  assign video_on_d  = w_sync_dly.video_on;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_sync_gen
// Brief   : Checks a default 640x480 instance and a shrunken-timing instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

  typedef struct packed {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       fs;
  } exp_t;

  logic       CLK;
  logic       RESET_N;

  logic       d_tick, d_von, d_hs, d_vs, d_hsd, d_vsd, d_vond, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_tick, s_von, s_hs, s_vs, s_hsd, s_vsd, s_vond, s_fs;
  logic [9:0] s_x, s_y;

  int    vectors    = 0;
  int    miscompares = 0;
  longint n_edges   = 0;

  vga_sync_gen u_dut_def (
    .CLK(CLK), .RESET_N(RESET_N), .p_tick(d_tick), .pix_x(d_x), .pix_y(d_y),
    .video_on(d_von), .hsync(d_hs), .vsync(d_vs), .hsync_d(d_hsd),
    .vsync_d(d_vsd), .video_on_d(d_vond), .frame_start(d_fs)
  );

  vga_sync_gen #(
    .H_DISPLAY(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
    .V_DISPLAY(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_DELAY(3)
  ) u_dut_small (
    .CLK(CLK), .RESET_N(RESET_N), .p_tick(s_tick), .pix_x(s_x), .pix_y(s_y),
    .video_on(s_von), .hsync(s_hs), .vsync(s_vs), .hsync_d(s_hsd),
    .vsync_d(s_vsd), .video_on_d(s_vond), .frame_start(s_fs)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected outputs after n rising edges since reset release (n<0: in reset).
  function automatic exp_t ref_at(input longint n,
                                  input longint hd, input longint hf, input longint hsw, input longint hb,
                                  input longint vd, input longint vf, input longint vsw, input longint vb);
    exp_t   e;
    longint ht, vt, t, x, y;
    e.pt = 1'b0; e.x = '0; e.y = '0; e.von = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0;
    if (n < 0) return e;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    t  = n / 4;
    x  = t % ht;
    y  = (t / ht) % vt;
    e.pt = (n % 4 == 3);
    e.x  = 10'(x);
    e.y  = 10'(y);
    if (n > 0) begin
      e.von = (x < hd) && (y < vd);
      e.hs  = !((x >= hd + hf) && (x < hd + hf + hsw));
      e.vs  = !((y >= vd + vf) && (y < vd + vf + vsw));
      e.fs  = (n % 4 == 0) && (t % (ht * vt) == 0);
    end
    return e;
  endfunction

  function automatic exp_t ref_def(input longint n);
    return ref_at(n, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic exp_t ref_small(input longint n);
    return ref_at(n, 20, 3, 5, 4, 6, 2, 2, 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s at edge %0d: observed=%h expected=%h", tag, n_edges, obs, exp_v);
    end
  endtask

  task automatic check_all();
    exp_t e, ed;
    vectors++;
    e  = ref_def(n_edges);
    ed = ref_def(n_edges - 2);
    check("def_main", 32'({d_tick, d_x, d_y, d_von, d_hs, d_vs, d_fs}), 32'(e));
    check("def_dly",  32'({d_hsd, d_vsd, d_vond}), 32'({ed.hs, ed.vs, ed.von}));
    e  = ref_small(n_edges);
    ed = ref_small(n_edges - 3);
    check("small_main", 32'({s_tick, s_x, s_y, s_von, s_hs, s_vs, s_fs}), 32'(e));
    check("small_dly",  32'({s_hsd, s_vsd, s_vond}), 32'({ed.hs, ed.vs, ed.von}));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK);
      n_edges++;
      @(negedge CLK);
      check_all();
    end
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    n_edges = 0;
    check_all();
  endtask

  // Drop reset between edges and confirm the outputs respond without a clock.
  task automatic async_reset(input int delay_ns);
    #(delay_ns);
    RESET_N = 1'b0;
    #1;
    n_edges = -1;
    check_all();
    @(negedge CLK);
    check_all();
  endtask

  initial begin
    RESET_N = 1'b0;
    n_edges = -1;
    repeat (3) @(negedge CLK);
    check_all();

    release_reset();
    // Covers p_tick phase, two full default lines including hsync and
    // the first pix_y step, and several frames of the shrunken instance.
    run(7000);

    // Mid-frame reset on the shrunken timing (x=17, y=7) then restart.
    async_reset(2);
    release_reset();
    run(4 * (32 * 7 + 17) + 2);
    async_reset(3);
    release_reset();
    run(40);

    for (int k = 0; k < 4; k++) begin
      run($urandom_range(200, 2500));
      async_reset($urandom_range(1, 4));
      repeat ($urandom_range(0, 3)) begin
        @(negedge CLK);
        check_all();
      end
      release_reset();
    end
    run(1700);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter: H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter: H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter: H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter: H_BACK, 48, horizontal back porch in pixels.
REQ-005 Parameter: V_DISPLAY, 480, visible lines per frame.
REQ-006 Parameter: V_FRONT, 10; V_SYNC, 2; V_BACK, 33 -- vertical porches and sync width in lines.
REQ-007 Parameter: SYNC_DELAY, 2, CLK cycles of delay on the aligned sync outputs (range 1-4).
REQ-008 CLK  input  1  system clock, 100 MHz.
REQ-009 RESET_N  input  1  asynchronous reset, active-low.
REQ-010 p_tick  output  1  pixel-enable strobe, one CLK wide.
REQ-011 pix_x  output  10  current horizontal count.
REQ-012 pix_y  output  10  current vertical count.
REQ-013 video_on  output  1  high when pix_x < H_DISPLAY and pix_y < V_DISPLAY.
REQ-014 hsync, vsync  output  1 each  active-low syncs, aligned with pix_x/pix_y.
REQ-015 hsync_d, vsync_d, video_on_d  output  1 each  hsync/vsync/video_on delayed SYNC_DELAY CLK cycles, aligned with the downstream registered RGB.
REQ-016 frame_start  output  1  one-CLK pulse when the counters wrap to (0,0).

Function
REQ-017 A 2-bit prescaler shall count 0..3 on every CLK edge; p_tick shall be high during the CLK cycle in which the prescaler equals 3 (25 MHz pixel rate).
REQ-018 h_count shall advance only on edges where p_tick is high; it shall wrap from H_TOTAL-1 (799) to 0, where H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK.
REQ-019 v_count shall advance only on the edge where h_count wraps; it shall wrap from V_TOTAL-1 (524) to 0.
REQ-020 pix_x shall equal h_count and pix_y shall equal v_count, both driven directly from registers.
REQ-021 hsync, vsync and video_on shall be registered and computed from the next-state counts, so they change on the same edge as pix_x/pix_y.
REQ-022 hsync shall be low for h_count in 656..751 inclusive, i.e. [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
REQ-023 vsync shall be low for v_count in 490..491 inclusive.
REQ-024 frame_start shall be high for exactly one CLK, on the edge where h_count=799 and v_count=524 with p_tick high.
REQ-025 The delayed outputs shall be a SYNC_DELAY-deep shift register clocked every CLK, with no p_tick gating.
REQ-026 Counter arithmetic shall be unsigned 10-bit; no count value shall exceed its TOTAL-1.

Reset
REQ-027 While RESET_N is low: prescaler=0, h_count=0, v_count=0, p_tick=0, frame_start=0, video_on=0, hsync=1, vsync=1, and every delay stage holds its inactive value (1 for syncs, 0 for video).
REQ-028 Reset asserted mid-line or mid-frame shall force the REQ-027 values immediately, without waiting for a clock edge.
REQ-029 After RESET_N deasserts, the first p_tick shall occur on the 4th CLK cycle, and counting shall restart from (0,0).

Structure
REQ-030 The VGA timing constants (640x480@60 values, H_TOTAL=800, V_TOTAL=525) shall live in a shared package, vga_timing_pkg, also imported by the pixel/text generator.
REQ-031 One sub-module, sync_delay_line (parameterised width and depth shift register), shall implement REQ-025.

Verification
REQ-032 Release reset, run 16 CLK -> p_tick high at cycles 4, 8, 12, 16; pix_x reaches 4; video_on=1 from the first edge.
REQ-033 Run to h_count=655->656 -> hsync falls on that edge; hsync rises at 751->752; low duration = 96x4 = 384 CLK.
REQ-034 Run a full line -> 3200 CLK between h wraps; pix_y increments exactly at the pix_x 799->0 edge; video_on=0 for pix_x 640..799.
REQ-035 Run a full frame -> vsync low for 2 lines (6400 CLK) starting at pix_y=490; frame_start pulses once per 1,680,000 CLK.
REQ-036 With SYNC_DELAY=2, compare outputs -> hsync_d/vsync_d/video_on_d equal hsync/vsync/video_on from exactly 2 CLK earlier.
REQ-037 Assert RESET_N low at pix_x=300, pix_y=200, between clock edges -> all outputs take REQ-027 values immediately; after release, counting restarts from (0,0).
